// File: rtl/spw_fct_pkg.sv
// Shared SpaceWire flow-control definitions for the TX credit logic
// and the FCT sender: state encoding and link credit constants.
package spw_fct_pkg;

    // Credit FSM state encoding (2-bit)
    typedef enum logic [1:0] {
        FCT_IDLE  = 2'd0,
        FCT_RUN   = 2'd1,
        FCT_ERROR = 2'd2
    } fct_state_e;

    // Credits granted by one FCT from the far end
    localparam int SPW_CREDIT_PER_FCT = 8;

    // Maximum legal outstanding credit (seven FCTs)
    localparam int SPW_MAX_CREDIT     = 56;

    // Counter width; must hold MAX_CREDIT + CREDIT_PER_FCT - 1
    localparam int SPW_CNT_W          = 6;

    // credit_low asserts at or below this level
    localparam int SPW_LOW_THRESH     = 8;

endpackage

// File: rtl/fct_credit_arith.sv
// Combinational next-credit calculation for the TX credit counter.
// Ports:
//   count        in   CNT_W  current outstanding credit
//   fct_received in   1      FCT pulse this cycle
//   nchar_sent   in   1      N-char pulse this cycle
//   next_count   out  CNT_W  count + inc - dec (low CNT_W bits)
//   overflow     out  1      net result exceeds MAX_CREDIT
//   underflow    out  1      N-char sent while count is zero
module fct_credit_arith
    import spw_fct_pkg::*;
#(
    parameter int CREDIT_PER_FCT = SPW_CREDIT_PER_FCT,
    parameter int MAX_CREDIT     = SPW_MAX_CREDIT,
    parameter int CNT_W          = SPW_CNT_W
) (
    input  logic [CNT_W-1:0] count,
    input  logic             fct_received,
    input  logic             nchar_sent,
    output logic [CNT_W-1:0] next_count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CNT_W:0] INC  = (CNT_W+1)'(CREDIT_PER_FCT);
    localparam logic [CNT_W:0] MAXC = (CNT_W+1)'(MAX_CREDIT);

    logic             zero;
    logic [CNT_W:0]   inc;
    logic [CNT_W:0]   dec;
    logic [CNT_W:0]   sum;

    // One extra bit so the intermediate sum cannot wrap
    always_comb begin
        zero       = (count == '0);
        inc        = fct_received ? INC : '0;
        dec        = {{CNT_W{1'b0}}, (nchar_sent && !zero)};
        sum        = {1'b0, count} + inc - dec;
        next_count = sum[CNT_W-1:0];
        overflow   = (sum > MAXC);
        underflow  = nchar_sent && zero;
    end

endmodule

// File: rtl/tx_fct_credit.sv
// Transmit-side SpaceWire flow-control credit counter with
// overflow (credit error) and underflow detection.
// Ports:
//   pclk_tx       in   1      TX clock
//   reset_tx      in   1      synchronous active-high reset
//   link_active   in   1      link in Connecting/Run; low clears credit
//   fct_received  in   1      FCT decoded by the receiver (pulse)
//   nchar_sent    in   1      N-char committed by the TX (pulse)
//   credit_count  out  CNT_W  outstanding credit
//   credit_avail  out  1      nonzero credit while running
//   credit_low    out  1      credit_count <= LOW_THRESH
//   credit_error  out  1      credit overflow, held in ERROR
//   underflow_err out  1      N-char sent with zero credit (pulse)
module tx_fct_credit
    import spw_fct_pkg::*;
#(
    parameter int CREDIT_PER_FCT = SPW_CREDIT_PER_FCT,
    parameter int MAX_CREDIT     = SPW_MAX_CREDIT,
    parameter int CNT_W          = SPW_CNT_W,
    parameter int LOW_THRESH     = SPW_LOW_THRESH
) (
    input  logic             pclk_tx,
    input  logic             reset_tx,
    input  logic             link_active,
    input  logic             fct_received,
    input  logic             nchar_sent,
    output logic [CNT_W-1:0] credit_count,
    output logic             credit_avail,
    output logic             credit_low,
    output logic             credit_error,
    output logic             underflow_err
);

    localparam logic [CNT_W-1:0] LOW_T = CNT_W'(LOW_THRESH);

    fct_state_e       state;
    logic [CNT_W-1:0] arith_next;
    logic             arith_ovf;
    logic             arith_unf;

    fct_credit_arith #(
        .CREDIT_PER_FCT (CREDIT_PER_FCT),
        .MAX_CREDIT     (MAX_CREDIT),
        .CNT_W          (CNT_W)
    ) u_arith (
        .count          (credit_count),
        .fct_received   (fct_received),
        .nchar_sent     (nchar_sent),
        .next_count     (arith_next),
        .overflow       (arith_ovf),
        .underflow      (arith_unf)
    );

    // Outputs are derived from the next count so that they line
    // up with credit_count in the same cycle.
    always_ff @(posedge pclk_tx) begin
        if (reset_tx) begin
            state         <= FCT_IDLE;
            credit_count  <= '0;
            credit_avail  <= 1'b0;
            credit_low    <= 1'b1;
            credit_error  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            unique case (state)
                FCT_IDLE: begin
                    credit_count  <= '0;
                    credit_avail  <= 1'b0;
                    credit_low    <= 1'b1;
                    credit_error  <= 1'b0;
                    underflow_err <= 1'b0;
                    if (link_active)
                        state <= FCT_RUN;
                end
                FCT_RUN: begin
                    if (!link_active) begin
                        state         <= FCT_IDLE;
                        credit_count  <= '0;
                        credit_avail  <= 1'b0;
                        credit_low    <= 1'b1;
                        underflow_err <= 1'b0;
                    end else if (arith_ovf) begin
                        // Count is frozen at its pre-overflow value
                        state         <= FCT_ERROR;
                        credit_error  <= 1'b1;
                        credit_avail  <= 1'b0;
                        underflow_err <= 1'b0;
                    end else begin
                        credit_count  <= arith_next;
                        credit_avail  <= (arith_next != '0);
                        credit_low    <= (arith_next <= LOW_T);
                        underflow_err <= arith_unf;
                    end
                end
                FCT_ERROR: begin
                    underflow_err <= 1'b0;
                    credit_avail  <= 1'b0;
                    if (!link_active) begin
                        state        <= FCT_IDLE;
                        credit_count <= '0;
                        credit_low   <= 1'b1;
                        credit_error <= 1'b0;
                    end
                end
                default: begin
                    state         <= FCT_IDLE;
                    credit_count  <= '0;
                    credit_avail  <= 1'b0;
                    credit_low    <= 1'b1;
                    credit_error  <= 1'b0;
                    underflow_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
